// File: rtl/kb_text_entry.sv
`default_nettype none
// ============================================================================
// Module      : kb_text_entry
// Description : PS/2 scan-code text entry buffer. Decodes E0/F0 prefixes,
//               suppresses typematic repeats, and edits a DIGITS-entry
//               buffer under a cursor (printable, backspace, escape, arrows).
//               Optional cursor blink: define KB_TEXT_CURSOR_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module kb_text_entry #(
  parameter int DIGITS    = 8,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                        CLK100MHZ,
  input  logic                        CPU_RESETN,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic                        clear,
  output logic [DIGITS*8-1:0]         buf_data,
  output logic [$clog2(DIGITS)-1:0]   cursor,
  output logic                        make_pulse,
  output logic [7:0]                  make_code,
  output logic                        make_ext,
  output logic [DIGITS-1:0]           blank_mask
);

  localparam int CW = $clog2(DIGITS);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  // Prefix decoder states
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EXT     = 2'd1;
  localparam logic [1:0] BRK     = 2'd2;
  localparam logic [1:0] EXT_BRK = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          held;
  logic          held_ext;
  logic [7:0]    held_code;
  logic [7:0]    entries [DIGITS];

  logic          is_make;
  logic          is_break;
  logic          is_ext;
  logic          key_match;
  logic          accept;
  logic          printable;
  logic [CW-1:0] cur_inc;
  logic [CW-1:0] cur_dec;

  // Byte decode: classify the incoming byte as prefix, make or break event
  always_comb begin
    state_nxt = state;
    is_make   = 1'b0;
    is_break  = 1'b0;
    is_ext    = 1'b0;
    if (rx_valid && !clear) begin
      case (state)
        IDLE: begin
          if (rx_data == 8'hE0) begin
            state_nxt = EXT;
          end else if (rx_data == 8'hF0) begin
            state_nxt = BRK;
          end else if (rx_data != 8'hAA && rx_data != 8'hFA &&
                       rx_data != 8'hFE && rx_data != 8'h00) begin
            is_make = 1'b1;
          end
        end
        EXT: begin
          if (rx_data == 8'hF0) begin
            state_nxt = EXT_BRK;
          end else begin
            is_make   = 1'b1;
            is_ext    = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          is_break  = 1'b1;
          state_nxt = IDLE;
        end
        EXT_BRK: begin
          is_break  = 1'b1;
          is_ext    = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Typematic filter: a make equal to the key still held down is a repeat
  assign key_match = held && (held_ext == is_ext) && (held_code == rx_data);
  assign accept    = is_make && !key_match;

  // Printable set: 01..83 minus modifiers, backspace and escape
  always_comb begin
    printable = (rx_data != 8'h00) && (rx_data <= 8'h83);
    case (rx_data)
      8'h11, 8'h12, 8'h14, 8'h58, 8'h59, 8'h66, 8'h76: printable = 1'b0;
      default: ;
    endcase
  end

  assign cur_inc = (cursor == LAST)     ? cursor : cursor + CW'(1);
  assign cur_dec = (cursor == '0)       ? cursor : cursor - CW'(1);

  // Prefix state, held-key tracking and registered make outputs
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state      <= IDLE;
      held       <= 1'b0;
      held_ext   <= 1'b0;
      held_code  <= 8'h00;
      make_pulse <= 1'b0;
      make_code  <= 8'h00;
      make_ext   <= 1'b0;
    end else begin
      make_pulse <= accept;
      if (clear) begin
        state <= IDLE;
        held  <= 1'b0;
      end else begin
        state <= state_nxt;
        if (accept) begin
          held      <= 1'b1;
          held_ext  <= is_ext;
          held_code <= rx_data;
          make_code <= rx_data;
          make_ext  <= is_ext;
        end else if (is_break && key_match) begin
          held <= 1'b0;
        end
      end
    end
  end

  // Buffer and cursor editing driven by accepted makes
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < DIGITS; i++) entries[i] <= 8'h00;
      cursor <= '0;
    end else if (clear) begin
      for (int i = 0; i < DIGITS; i++) entries[i] <= 8'h00;
      cursor <= '0;
    end else if (accept) begin
      if (!is_ext) begin
        if (rx_data == 8'h76) begin
          for (int i = 0; i < DIGITS; i++) entries[i] <= 8'h00;
          cursor <= '0;
        end else if (rx_data == 8'h66) begin
          entries[cur_dec] <= 8'h00;
          cursor           <= cur_dec;
        end else if (printable) begin
          entries[cursor] <= rx_data;
          cursor          <= cur_inc;
        end
      end else begin
        if (rx_data == 8'h6B) begin
          cursor <= cur_inc;
        end else if (rx_data == 8'h74) begin
          cursor <= cur_dec;
        end
      end
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_pack
    assign buf_data[8*i +: 8] = entries[i];
  end

`ifdef KB_TEXT_CURSOR_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          phase;

  // Blink timer; a fresh key press restarts it so the cursor digit shows
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (accept) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign blank_mask = {{(DIGITS-1){1'b0}}, phase} << cursor;
`else
  logic [31:0] unused_blink_div;
  assign unused_blink_div = BLINK_DIV;
  assign blank_mask       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_kb_text_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_kb_text_entry
// Description : Scoreboard bench for kb_text_entry. Stimulus pushes the
//               reference model's expected response; a monitor pops and
//               compares whenever the DUT has consumed a byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kb_text_entry;
  localparam int DIGITS    = 8;
  localparam int BLINK_DIV = 4;
  localparam int CW        = $clog2(DIGITS);

  logic                 clk = 1'b0;
  logic                 rstn = 1'b1;
  logic [7:0]           rx_data = 8'h00;
  logic                 rx_valid = 1'b0;
  logic                 clear = 1'b0;
  logic [DIGITS*8-1:0]  buf_data;
  logic [CW-1:0]        cursor;
  logic                 make_pulse;
  logic [7:0]           make_code;
  logic                 make_ext;
  logic [DIGITS-1:0]    blank_mask;

  kb_text_entry #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rstn),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .clear     (clear),
    .buf_data  (buf_data),
    .cursor    (cursor),
    .make_pulse(make_pulse),
    .make_code (make_code),
    .make_ext  (make_ext),
    .blank_mask(blank_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                pulse;
    logic [7:0]          code;
    logic                ext;
    logic [DIGITS*8-1:0] bufv;
    logic [CW-1:0]       cur;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   pulse_cnt = 0;
  logic due = 1'b0;

  // Reference model: text buffer as an array, prefixes as pending flags
  logic [7:0] m_ent [DIGITS];
  int         m_cur;
  bit         m_pext, m_pbrk, m_held, m_hext;
  logic [7:0] m_hcode;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DIGITS; i++) m_ent[i] = 8'h00;
    m_cur = 0; m_pext = 0; m_pbrk = 0; m_held = 0; m_hext = 0; m_hcode = 8'h00;
  endfunction

  function automatic bit is_printable(input logic [7:0] c);
    return (c >= 8'h01) && (c <= 8'h83) &&
           !(c inside {8'h11, 8'h12, 8'h14, 8'h58, 8'h59, 8'h66, 8'h76});
  endfunction

  function automatic logic [DIGITS*8-1:0] model_buf();
    logic [DIGITS*8-1:0] b;
    for (int i = 0; i < DIGITS; i++) b[8*i +: 8] = m_ent[i];
    return b;
  endfunction

  function automatic void model_apply(input bit v, input logic [7:0] d, input bit c, output exp_t e);
    bit ext, brk, same;
    e.pulse = 1'b0; e.code = 8'h00; e.ext = 1'b0;
    if (c) begin
      for (int i = 0; i < DIGITS; i++) m_ent[i] = 8'h00;
      m_cur = 0; m_pext = 0; m_pbrk = 0; m_held = 0;
    end else if (v) begin
      if (!m_pext && !m_pbrk && d == 8'hE0) m_pext = 1;
      else if (!m_pbrk && d == 8'hF0) m_pbrk = 1;
      else if (!m_pext && !m_pbrk && (d inside {8'hAA, 8'hFA, 8'hFE, 8'h00})) ;
      else begin
        ext = m_pext; brk = m_pbrk; m_pext = 0; m_pbrk = 0;
        same = m_held && (m_hext == ext) && (m_hcode == d);
        if (brk) begin
          if (same) m_held = 0;
        end else if (!same) begin
          m_held = 1; m_hext = ext; m_hcode = d;
          e.pulse = 1'b1; e.code = d; e.ext = ext;
          if (!ext) begin
            if (d == 8'h76) begin
              for (int i = 0; i < DIGITS; i++) m_ent[i] = 8'h00;
              m_cur = 0;
            end else if (d == 8'h66) begin
              if (m_cur > 0) m_cur--;
              m_ent[m_cur] = 8'h00;
            end else if (is_printable(d)) begin
              m_ent[m_cur] = d;
              if (m_cur < DIGITS - 1) m_cur++;
            end
          end else if (d == 8'h6B) begin
            if (m_cur < DIGITS - 1) m_cur++;
          end else if (d == 8'h74) begin
            if (m_cur > 0) m_cur--;
          end
        end
      end
    end
    e.bufv = model_buf();
    e.cur  = CW'(m_cur);
  endfunction

  task automatic step(input bit v, input logic [7:0] d, input bit c);
    exp_t e;
    @(posedge clk); #1;
    rx_valid = v; rx_data = d; clear = c;
    model_apply(v, d, c, e);
    if (v || c) exp_q.push_back(e);
    @(posedge clk); #1;
    rx_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  function automatic logic [7:0] entry(input int i);
    return buf_data[8*i +: 8];
  endfunction

  // Marks cycles in which the DUT consumed a byte or a clear
  always @(posedge clk) due <= rx_valid | clear;

  // Monitor: compare DUT response against the scoreboard head
  always @(negedge clk) begin
    if (rstn) begin
      if (due) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          if (make_pulse) pulse_cnt++;
          chk("make_pulse", make_pulse, mon_e.pulse);
          if (mon_e.pulse) begin
            chk("make_code", make_code, mon_e.code);
            chk("make_ext", make_ext, mon_e.ext);
          end
          chk("buf_data", buf_data, mon_e.bufv);
          chk("cursor", cursor, mon_e.cur);
`ifndef KB_TEXT_CURSOR_BLINK_EN
          chk("blank_mask_off", blank_mask, 0);
`endif
        end
      end else begin
        chk("idle_make_pulse", make_pulse, 0);
      end
    end
  end

  logic [7:0] pool [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h45, 8'h16};
  logic [7:0] nine [9]  = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int r;
    logic [7:0] b;
    logic [7:0] last_b;
    bit c;
    model_reset();
    #1 rstn = 1'b0;
    #20;
    chk("reset_buf", buf_data, 0);
    chk("reset_cursor", cursor, 0);
    chk("reset_pulse", make_pulse, 0);
    chk("reset_code", make_code, 0);
    chk("reset_ext", make_ext, 0);
    chk("reset_blank", blank_mask, 0);
    #2 rstn = 1'b1;

    // Make/break/make
    p0 = pulse_cnt;
    step(1, 8'h1C, 0); step(1, 8'hF0, 0); step(1, 8'h1C, 0); step(1, 8'h32, 0);
    settle();
    chk("basic_pulses", pulse_cnt - p0, 2);
    chk("basic_e0", entry(0), 8'h1C);
    chk("basic_e1", entry(1), 8'h32);
    chk("basic_cur", cursor, 2);

    // Typematic repeats suppressed until release
    step(0, 8'h00, 1);
    p0 = pulse_cnt;
    step(1, 8'h1C, 0); step(1, 8'h1C, 0); step(1, 8'h1C, 0);
    step(1, 8'hF0, 0); step(1, 8'h1C, 0); step(1, 8'h1C, 0);
    settle();
    chk("typematic_pulses", pulse_cnt - p0, 2);
    chk("typematic_e0", entry(0), 8'h1C);
    chk("typematic_e1", entry(1), 8'h1C);
    chk("typematic_cur", cursor, 2);

    // Cursor saturation and arrows
    step(0, 8'h00, 1);
    for (int i = 0; i < 9; i++) step(1, nine[i], 0);
    settle();
    chk("sat_cur", cursor, 7);
    chk("sat_e7", entry(7), 8'h46);
    chk("sat_e6", entry(6), 8'h3D);
    step(1, 8'hE0, 0); step(1, 8'h74, 0);
    settle();
    chk("right_cur", cursor, 6);
    for (int i = 0; i < 3; i++) begin step(1, 8'hE0, 0); step(1, 8'h6B, 0); end
    settle();
    chk("left_cur", cursor, 7);

    // Backspace then escape
    step(0, 8'h00, 1);
    step(1, 8'h1C, 0); step(1, 8'h32, 0); step(1, 8'h21, 0);
    step(1, 8'h66, 0);
    settle();
    chk("bksp_cur", cursor, 2);
    chk("bksp_e2", entry(2), 8'h00);
    chk("bksp_e1", entry(1), 8'h32);
    step(1, 8'h76, 0);
    settle();
    chk("esc_buf", buf_data, 0);
    chk("esc_cur", cursor, 0);

    // Clear wins over a same-cycle byte and aborts a pending prefix
    p0 = pulse_cnt;
    step(1, 8'hE0, 0); step(1, 8'h1C, 1);
    settle();
    chk("clear_no_pulse", pulse_cnt - p0, 0);
    step(1, 8'h1C, 0);
    settle();
    chk("clear_next_e0", entry(0), 8'h1C);
    chk("clear_next_ext", make_ext, 0);

    // Asynchronous reset mid-prefix
    step(1, 8'hE0, 0);
    @(posedge clk); #1 rstn = 1'b0;
    #2;
    chk("async_rst_buf", buf_data, 0);
    chk("async_rst_cur", cursor, 0);
    model_reset();
    #2 rstn = 1'b1;
    step(1, 8'h1C, 0);
    settle();
    chk("post_rst_ext", make_ext, 0);
    chk("post_rst_e0", entry(0), 8'h1C);

`ifdef KB_TEXT_CURSOR_BLINK_EN
    // Blink: cursor at 2, restart on accepted makes
    step(0, 8'h00, 1);
    step(1, 8'h1C, 0); step(1, 8'h32, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("blink_mask", blank_mask, ((k / BLINK_DIV) % 2) ? 8'h04 : 8'h00);
    end
    step(1, 8'hE0, 0); step(1, 8'h11, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("blink_restart", blank_mask, ((k / BLINK_DIV) % 2) ? 8'h04 : 8'h00);
    end
`endif

    // Randomized traffic
    last_b = 8'h1C;
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if      (r < 30) b = pool[$urandom_range(0, 9)];
      else if (r < 40) b = 8'hF0;
      else if (r < 50) b = 8'hE0;
      else if (r < 55) b = 8'h66;
      else if (r < 58) b = 8'h76;
      else if (r < 65) b = 8'h6B;
      else if (r < 70) b = 8'h74;
      else if (r < 75) b = ($urandom_range(0, 1) != 0) ? 8'h11 : 8'h12;
      else if (r < 78) b = ($urandom_range(0, 1) != 0) ? 8'hAA : 8'h00;
      else             b = last_b;
      c = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 9) == 0) step(0, 8'h00, 0);
      step(1, b, c);
      last_b = b;
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire
